// File: rtl/shared_fft_bram_banked.sv
// Shared banked coefficient store between the FFT core and the key-switch / RNS datapaths.
// Latency: every read returns BRAM_RD_LAT cycles after its enable; a mode change waits BRAM_RD_LAT cycles for reads to drain.
// Backpressure: none; enables on an inactive port or during a drain are dropped and raise sticky err_conflict.
module shared_fft_bram_banked #(
    parameter int LOGN         = 13,
    parameter int LOGQ         = 54,
    parameter int FLP_WORDSIZE = 64,
    parameter int BRAM_RD_LAT  = 2,
    parameter int LOG_BANKS    = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   mode_req,
    input  logic                                                   mode_req_vld,
    output logic                                                   mode_ack,
    output logic                                                   is_fft,
    output logic                                                   busy,
    input  logic [(2**LOG_BANKS)-1:0]                              fft_rd_en,
    input  logic [(2**LOG_BANKS)*(LOGN-LOG_BANKS)-1:0]             fft_rd_addr,
    output logic [(2**LOG_BANKS)*2*FLP_WORDSIZE-1:0]               fft_rd_data,
    output logic [(2**LOG_BANKS)-1:0]                              fft_rd_vld,
    input  logic [(2**LOG_BANKS)-1:0]                              fft_wea,
    input  logic [(2**LOG_BANKS)*(LOGN-LOG_BANKS)-1:0]             fft_wr_addr,
    input  logic [(2**LOG_BANKS)*2*FLP_WORDSIZE-1:0]               fft_wr_data,
    input  logic                                                   rns_rd_en,
    input  logic [LOGN-1:0]                                        rns_rd_addr,
    output logic [FLP_WORDSIZE-1:0]                                rns_rd_data,
    output logic                                                   rns_rd_vld,
    input  logic                                                   key_rd_en,
    input  logic [LOGN-1:0]                                        key_rd_addr,
    output logic [LOGQ-1:0]                                        key_rd_data,
    output logic                                                   key_rd_vld,
    input  logic                                                   key_wea,
    input  logic [LOGN-1:0]                                        key_wr_addr,
    input  logic [LOGQ-1:0]                                        key_wr_data,
    output logic                                                   err_conflict,
    input  logic                                                   err_clr
);
    localparam int W  = FLP_WORDSIZE;
    localparam int NB = 2**LOG_BANKS;
    localparam int BA = LOGN - LOG_BANKS;
    localparam int D  = 2**BA;
    localparam int HW = 2*W - LOGQ;
    localparam int CW = $clog2(BRAM_RD_LAT + 1);

    typedef enum logic [1:0] {ST_KEY, ST_FFT, ST_DRAIN} state_e;

    state_e        state_q, state_d;
    logic          target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic          fft_ok, key_ok, conflict;
    logic [NB-1:0] fft_rd_acc, fft_we_acc;
    logic          key_rd_acc, rns_rd_acc, key_we_acc;

    logic [BRAM_RD_LAT-1:0][NB-1:0]        fft_vld_q;
    logic [BRAM_RD_LAT-1:0]                key_vld_q, rns_vld_q;
    logic [BRAM_RD_LAT-1:0][LOG_BANKS-1:0] key_bank_q, rns_bank_q;

    logic [NB-1:0][LOGQ-1:0] lo_out;
    logic [NB-1:0][HW-1:0]   hi_out;

    // Mode FSM: same-mode requests are just acknowledged, a change drains in-flight reads first.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        unique case (state_q)
            ST_KEY, ST_FFT: begin
                if (mode_req_vld) begin
                    if (mode_req == (state_q == ST_FFT)) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d  = ST_DRAIN;
                        target_d = mode_req;
                        cnt_d    = CW'(BRAM_RD_LAT);
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                // The last accepted read leaves the pipeline on the edge the count hits zero.
                if (cnt_q <= CW'(1)) begin
                    state_d = target_q ? ST_FFT : ST_KEY;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = ST_KEY;
        endcase
    end

    // Port gating and misuse detection; conflict beats a same-cycle clear.
    always_comb begin
        fft_ok     = (state_q == ST_FFT);
        key_ok     = (state_q == ST_KEY);
        conflict   = (((|fft_rd_en) || (|fft_wea)) && !fft_ok) ||
                     ((key_rd_en || rns_rd_en || key_wea) && !key_ok);
        fft_rd_acc = fft_ok ? fft_rd_en : '0;
        fft_we_acc = fft_ok ? fft_wea : '0;
        key_rd_acc = key_ok && key_rd_en;
        rns_rd_acc = key_ok && rns_rd_en;
        key_we_acc = key_ok && key_wea;
        err_d      = conflict ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_KEY;
            target_q <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Valid and bank-select pipelines, aligned with the data pipeline inside each bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_vld_q  <= '0;
            key_vld_q  <= '0;
            rns_vld_q  <= '0;
            key_bank_q <= '0;
            rns_bank_q <= '0;
        end else begin
            fft_vld_q[0]  <= fft_rd_acc;
            key_vld_q[0]  <= key_rd_acc;
            rns_vld_q[0]  <= rns_rd_acc;
            key_bank_q[0] <= key_rd_addr[LOG_BANKS-1:0];
            rns_bank_q[0] <= rns_rd_addr[LOG_BANKS-1:0];
            for (int k = 1; k < BRAM_RD_LAT; k++) begin
                fft_vld_q[k]  <= fft_vld_q[k-1];
                key_vld_q[k]  <= key_vld_q[k-1];
                rns_vld_q[k]  <= rns_vld_q[k-1];
                key_bank_q[k] <= key_bank_q[k-1];
                rns_bank_q[k] <= rns_bank_q[k-1];
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [LOGQ-1:0] lo_mem [D];
        logic [HW-1:0]   hi_mem [D];
        logic [LOGQ-1:0] lo_pipe_q [BRAM_RD_LAT];
        logic [HW-1:0]   hi_pipe_q [BRAM_RD_LAT];
        logic            lo_we, hi_we;
        logic [BA-1:0]   lo_waddr, hi_waddr, lo_raddr, hi_raddr;
        logic [LOGQ-1:0] lo_wdat;
        logic [HW-1:0]   hi_wdat;

        // Port steering: the FFT port owns the bank in FFT mode, otherwise the key/RNS row decode does.
        always_comb begin
            hi_we    = fft_we_acc[b];
            hi_waddr = fft_wr_addr[b*BA +: BA];
            hi_wdat  = fft_wr_data[b*2*W+LOGQ +: HW];
            lo_we    = fft_we_acc[b] ||
                       (key_we_acc && (key_wr_addr[LOG_BANKS-1:0] == LOG_BANKS'(b)));
            lo_waddr = fft_ok ? fft_wr_addr[b*BA +: BA] : key_wr_addr[LOGN-1:LOG_BANKS];
            lo_wdat  = fft_ok ? fft_wr_data[b*2*W +: LOGQ] : key_wr_data;
            lo_raddr = fft_ok ? fft_rd_addr[b*BA +: BA] : key_rd_addr[LOGN-1:LOG_BANKS];
            hi_raddr = fft_ok ? fft_rd_addr[b*BA +: BA] : rns_rd_addr[LOGN-1:LOG_BANKS];
        end

        // Read-first storage: the registered read sees contents from before this edge's write.
        always_ff @(posedge clk) begin
            if (lo_we) lo_mem[lo_waddr] <= lo_wdat;
            if (hi_we) hi_mem[hi_waddr] <= hi_wdat;
            lo_pipe_q[0] <= lo_mem[lo_raddr];
            hi_pipe_q[0] <= hi_mem[hi_raddr];
            for (int k = 1; k < BRAM_RD_LAT; k++) begin
                lo_pipe_q[k] <= lo_pipe_q[k-1];
                hi_pipe_q[k] <= hi_pipe_q[k-1];
            end
        end

        assign lo_out[b] = lo_pipe_q[BRAM_RD_LAT-1];
        assign hi_out[b] = hi_pipe_q[BRAM_RD_LAT-1];
        assign fft_rd_data[b*2*W +: 2*W] = {hi_out[b], lo_out[b]};
    end

    assign fft_rd_vld   = fft_vld_q[BRAM_RD_LAT-1];
    assign key_rd_vld   = key_vld_q[BRAM_RD_LAT-1];
    assign rns_rd_vld   = rns_vld_q[BRAM_RD_LAT-1];
    assign key_rd_data  = lo_out[key_bank_q[BRAM_RD_LAT-1]];
    assign rns_rd_data  = hi_out[rns_bank_q[BRAM_RD_LAT-1]][HW-1 -: W];
    assign mode_ack     = ack_q;
    assign busy         = (state_q == ST_DRAIN);
    // During a drain the outgoing mode is still reported.
    assign is_fft       = (state_q == ST_FFT) || ((state_q == ST_DRAIN) && !target_q);
    assign err_conflict = err_q;

endmodule
